mips_main_ctrl: RTL
===================

Name: mips_main_ctrl

Overview:
- Multicycle main control FSM for the 32-bit MIPS core.
- Sequences the datapath through fetch, decode, execute, memory and write-back. Drives every datapath control input from a state register, the instruction opcode and a memory ready handshake.
- Sits beside the datapath: consumes `op`, drives the datapath control pins, and drives the memory read/write strobes.
- The ALU controller consumes `ALUOp` together with `funct`.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  opcode from the instruction register
- memReady  in  1  memory has completed the current read/write this cycle
- PCWriteCond  out  1  PC write if zero
- PCWrite  out  1  unconditional PC write
- PCSource  out  2  next PC: 0 aluResult, 1 aluOut, 2 jump target
- IorD  out  1  memory address: 0 PC, 1 aluOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemToReg  out  1  register write data: 0 aluOut, 1 mem reg
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register file write
- RegDst  out  1  write address: 0 rt, 1 rd
- ALUSrcA  out  1  0 PC, 1 A register
- ALUSrcB  out  2  0 B register, 1 const 4, 2 sign-extended imm, 3 sign-extended imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- illegalOp  out  1  sticky flag: an unsupported opcode was decoded

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0:
  - state=FETCH, illegalOp=0.
  - All outputs forced 0: PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, plus all mux selects and ALUOp.
- Output timing: Moore outputs, decoded combinationally from the state register. Strobes in wait states are additionally ANDed with memReady, as listed per state. No output depends on `op`.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0.
  - IRWrite=memReady, PCWrite=memReady.
  - Transitions: memReady=0 -> stay; memReady=1 -> DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=3, ALUOp=00 (branch target into aluOut).
  - Transitions on op: LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; ADDI -> ADDIEX; J -> JEX.
  - Any other op -> FETCH and set illegalOp=1 on that edge; illegalOp is cleared only by reset.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=2, ALUOp=00.
  - Transitions: op==LW -> MEMRD, else -> MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Transitions: hold until memReady=1, then -> MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, RegDst=0, MemToReg=1.
  - Transition: -> FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Transitions: hold until memReady=1, then -> FETCH.
- RTYPEEX:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUOp=10.
  - Transition: -> RTYPEWB.
- RTYPEWB:
  - Outputs: RegWrite=1, RegDst=1, MemToReg=0.
  - Transition: -> FETCH.
- BEQEX:
  - Outputs: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1.
  - Transition: -> FETCH.
- ADDIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=2, ALUOp=00.
  - Transition: -> ADDIWB.
- ADDIWB:
  - Outputs: RegWrite=1, RegDst=0, MemToReg=0.
  - Transition: -> FETCH.
- JEX:
  - Outputs: PCWrite=1, PCSource=2.
  - Transition: -> FETCH.
- Latency with memReady tied 1 (cycles from FETCH entry back to FETCH): LW 5; SW, R-type and ADDI 4; BEQ and J 3; illegal op 2.
- Each memory wait cycle adds 1.
- MemRead/MemWrite stay asserted for the whole wait. Address selection (IorD) is stable across the wait.
- Unreachable state encodings -> FETCH on the next edge; no outputs are asserted in them.
- Reset asserted mid-instruction: write enables drop immediately (asynchronously). On release the FSM starts at FETCH; a partially executed instruction is abandoned.
- `op` is sampled only in DECODE and MEMADR. IR is stable there because IRWrite is 0 outside FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - State enumeration, 4-bit encoding.
  - Opcode constants.
  - ALUOp codes.
  - Mux-select constants for PCSource, ALUSrcB and IorD.
- One sub-module, mips_ctrl_decode: purely combinational state -> control-word decode, with memReady gating.
- The top level holds the state register, the next-state logic and illegalOp.

Test Plan:
- Reset: reset=0 with memReady=1 -> all outputs 0, illegalOp=0. After release, the first cycle shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=1.
- R-type: op=000000, memReady=1 -> states FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH. ALUOp=10 in EX; RegWrite=1 and RegDst=1 in WB only.
- LW with waits: op=100011, memReady low for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Response: 10-cycle instruction; IRWrite and PCWrite pulse once, exactly on the memReady cycle.
  - MemRead=1 and IorD=1 held through MEMRD; RegWrite=1 with MemToReg=1 in MEMWB.
- SW and BEQ: op=101011 -> MemWrite=1 with IorD=1, held until memReady, no RegWrite. op=000100 -> BEQEX has PCWriteCond=1, PCSource=1, ALUOp=01, PCWrite=0.
- J and illegal op:
  - op=000010 -> JEX has PCWrite=1, PCSource=2, 3-cycle instruction.
  - op=111111 -> DECODE returns to FETCH, illegalOp=1 and stays 1 until reset.
- Mid-operation reset: reset pulled low during MEMWR with MemWrite=1 -> MemWrite drops in the same cycle (no clock edge needed). After release the FSM is in FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller:
// state encoding, opcodes, ALUOp codes, mux selects and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_main_ctrl_if.sv
// Controller <-> datapath/memory control bus. The controller is the master.
interface mips_main_ctrl_if;
  logic [5:0] op;
  logic       memReady;
  logic       PCWriteCond;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       illegalOp;

  modport master (
    input  op, memReady,
    output PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite, MemToReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, illegalOp
  );

  modport slave (
    output op, memReady,
    input  PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite, MemToReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, illegalOp
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Purely combinational state -> control word decode. i_enable low (reset held)
// forces the whole word to zero so write strobes drop without a clock edge.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_ready,
  input  logic   i_enable,
  output ctrl_t  o_ctrl
);

  ctrl_t w_ctrl;

  // Moore decode; only FETCH's IR/PC load is qualified by memReady
  always_comb begin
    w_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = IORD_PC;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SL2;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = IORD_ALUOUT;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = IORD_ALUOUT;
      end
      S_RTYPEEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
      end
      S_BEQEX: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
      end
      S_JEX: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = i_enable ? w_ctrl : ctrl_t'('0);

endmodule

// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic and the
// sticky illegal-opcode flag; control outputs come from mips_ctrl_decode.
module mips_main_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mips_main_ctrl_if.master ctrl_bus
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  logic   w_set_illegal;
  ctrl_t  w_ctrl;

  // Next-state decode; op is only looked at in DECODE and MEMADR
  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = ctrl_bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl_bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (ctrl_bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = ctrl_bus.memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = ctrl_bus.memReady ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // State register and sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  mips_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (ctrl_bus.memReady),
    .i_enable    (reset),
    .o_ctrl      (w_ctrl)
  );

  assign ctrl_bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign ctrl_bus.PCWrite     = w_ctrl.pc_write;
  assign ctrl_bus.PCSource    = w_ctrl.pc_source;
  assign ctrl_bus.IorD        = w_ctrl.iord;
  assign ctrl_bus.MemRead     = w_ctrl.mem_read;
  assign ctrl_bus.MemWrite    = w_ctrl.mem_write;
  assign ctrl_bus.MemToReg    = w_ctrl.mem_to_reg;
  assign ctrl_bus.IRWrite     = w_ctrl.ir_write;
  assign ctrl_bus.RegWrite    = w_ctrl.reg_write;
  assign ctrl_bus.RegDst      = w_ctrl.reg_dst;
  assign ctrl_bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign ctrl_bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign ctrl_bus.ALUOp       = w_ctrl.alu_op;
  assign ctrl_bus.illegalOp   = r_illegal;

endmodule
